// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC register, direct-mapped word icache,
// miss handling towards the memory controller, branch predecode and a
// circular instruction queue feeding the dispatcher.
module fetch_queue_unit #(
    parameter int          ICACHE_IDX_W = 6,
    parameter int          IQ_DEPTH_W   = 3,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_done_in,
    input  logic [31:0] mem_inst_in,
    output logic        mem_abort_out,
    output logic        pred_query_out,
    output logic [31:0] pred_pc_out,
    input  logic        pred_taken_in,
    output logic        iq_valid_out,
    input  logic        iq_ready_in,
    output logic [31:0] iq_inst_out,
    output logic [31:0] iq_pc_out,
    output logic        iq_pred_taken_out,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in,
    input  logic        icache_clear_in
);

    localparam int ENTRIES  = 1 << ICACHE_IDX_W;
    localparam int TAG_W    = 32 - ICACHE_IDX_W - 2;
    localparam int IQ_DEPTH = 1 << IQ_DEPTH_W;
    localparam logic [IQ_DEPTH_W:0]   IQ_FULL = {1'b1, {IQ_DEPTH_W{1'b0}}};
    localparam logic [IQ_DEPTH_W:0]   CNT_ONE = {{IQ_DEPTH_W{1'b0}}, 1'b1};
    localparam logic [IQ_DEPTH_W-1:0] PTR_ONE = {{(IQ_DEPTH_W-1){1'b0}}, 1'b1};

    typedef enum logic {ST_FETCH, ST_MISS} state_t;

    state_t              state_reg;
    logic [31:0]         pc_reg;

    logic [31:0]         cache_data [ENTRIES];
    logic [TAG_W-1:0]    cache_tag  [ENTRIES];
    logic [ENTRIES-1:0]  valid_reg;

    logic [31:0]         iq_inst_mem  [IQ_DEPTH];
    logic [31:0]         iq_pc_mem    [IQ_DEPTH];
    logic                iq_taken_mem [IQ_DEPTH];
    logic [IQ_DEPTH_W-1:0] head_reg;
    logic [IQ_DEPTH_W-1:0] tail_reg;
    logic [IQ_DEPTH_W:0]   count_reg;

    logic [ICACHE_IDX_W-1:0] idx;
    logic [TAG_W-1:0]        tag;
    logic        live;
    logic        hit;
    logic        lookup;
    logic        start_miss;
    logic        fill;
    logic        push;
    logic        pop;
    logic        cache_we;
    logic [31:0] push_inst;
    logic        is_jal;
    logic        is_branch;
    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic        push_taken;
    logic [31:0] next_pc;

    assign idx  = pc_reg[ICACHE_IDX_W+1:2];
    assign tag  = pc_reg[31:ICACHE_IDX_W+2];
    // A flush overrides every other activity in its cycle.
    assign live = rdy_in && !flush_in;
    assign hit  = valid_reg[idx] && (cache_tag[idx] == tag);

    // Lookup only when a queue slot is free; a miss keeps that slot reserved
    // because nothing else pushes while the fill is outstanding.
    assign lookup     = live && (state_reg == ST_FETCH) && (count_reg != IQ_FULL);
    assign start_miss = lookup && !hit;
    assign fill       = live && (state_reg == ST_MISS) && mem_done_in;
    assign push       = (lookup && hit) || fill;
    assign cache_we   = fill && !icache_clear_in;
    assign push_inst  = fill ? mem_inst_in : cache_data[idx];

    // Predecode of the word being pushed to pick the next fetch address.
    assign is_jal     = (push_inst[6:0] == 7'b1101111);
    assign is_branch  = (push_inst[6:0] == 7'b1100011);
    assign imm_j      = {{11{push_inst[31]}}, push_inst[31], push_inst[19:12],
                         push_inst[20], push_inst[30:21], 1'b0};
    assign imm_b      = {{19{push_inst[31]}}, push_inst[31], push_inst[7],
                         push_inst[30:25], push_inst[11:8], 1'b0};
    assign push_taken = is_jal || (is_branch && pred_taken_in);

    // Next PC: JAL always redirects, branches follow the predictor.
    always_comb begin
        next_pc = pc_reg + 32'd4;
        if (is_jal)
            next_pc = pc_reg + imm_j;
        else if (is_branch && pred_taken_in)
            next_pc = pc_reg + imm_b;
    end

    assign pred_query_out = push && is_branch;
    assign pred_pc_out    = pred_query_out ? pc_reg : 32'h0;

    assign iq_valid_out      = (count_reg != '0);
    assign pop               = iq_valid_out && iq_ready_in && live;
    assign iq_inst_out       = iq_valid_out ? iq_inst_mem[head_reg] : 32'h0;
    assign iq_pc_out         = iq_valid_out ? iq_pc_mem[head_reg]   : 32'h0;
    assign iq_pred_taken_out = iq_valid_out && iq_taken_mem[head_reg];

    // Fetch control, memory request handshake and queue pointers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg     <= ST_FETCH;
            pc_reg        <= RESET_PC;
            mem_req_out   <= 1'b0;
            mem_addr_out  <= 32'h0;
            mem_abort_out <= 1'b0;
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
        end else if (rdy_in) begin
            mem_abort_out <= flush_in && (state_reg == ST_MISS);
            if (flush_in) begin
                state_reg   <= ST_FETCH;
                pc_reg      <= flush_pc_in;
                mem_req_out <= 1'b0;
                head_reg    <= '0;
                tail_reg    <= '0;
                count_reg   <= '0;
            end else begin
                if (start_miss) begin
                    mem_req_out  <= 1'b1;
                    mem_addr_out <= pc_reg;
                    state_reg    <= ST_MISS;
                end
                if (fill) begin
                    mem_req_out <= 1'b0;
                    state_reg   <= ST_FETCH;
                end
                if (push) begin
                    pc_reg   <= next_pc;
                    tail_reg <= tail_reg + PTR_ONE;
                end
                if (pop)
                    head_reg <= head_reg + PTR_ONE;
                if (push && !pop)
                    count_reg <= count_reg + CNT_ONE;
                else if (pop && !push)
                    count_reg <= count_reg - CNT_ONE;
            end
        end
    end

    // Per-entry valid bits: bulk clear wins over a coincident fill.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in)
                    valid_reg[gi] <= 1'b0;
                else if (rdy_in) begin
                    if (icache_clear_in)
                        valid_reg[gi] <= 1'b0;
                    else if (cache_we && (idx == ICACHE_IDX_W'(gi)))
                        valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Cache data/tag storage written on a completed fill.
    always_ff @(posedge clk_in) begin
        if (cache_we) begin
            cache_data[idx] <= mem_inst_in;
            cache_tag[idx]  <= tag;
        end
    end

    // Queue storage written at the tail on every push.
    always_ff @(posedge clk_in) begin
        if (push) begin
            iq_inst_mem[tail_reg]  <= push_inst;
            iq_pc_mem[tail_reg]    <= pc_reg;
            iq_taken_mem[tail_reg] <= push_taken;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: a behavioural memory, a
// program-level model of the expected instruction stream, and directed
// plus randomized scenarios.
module tb_fetch_queue_unit;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_done_in = 1'b0;
    logic [31:0] mem_inst_in = 32'h0;
    logic        mem_abort_out;
    logic        pred_query_out;
    logic [31:0] pred_pc_out;
    logic        pred_taken_in;
    logic        iq_valid_out;
    logic        iq_ready_in = 1'b0;
    logic [31:0] iq_inst_out;
    logic [31:0] iq_pc_out;
    logic        iq_pred_taken_out;
    logic        flush_in = 1'b0;
    logic [31:0] flush_pc_in = 32'h0;
    logic        icache_clear_in = 1'b0;

    always #5 clk_in = ~clk_in;

    fetch_queue_unit dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .mem_req_out       (mem_req_out),
        .mem_addr_out      (mem_addr_out),
        .mem_done_in       (mem_done_in),
        .mem_inst_in       (mem_inst_in),
        .mem_abort_out     (mem_abort_out),
        .pred_query_out    (pred_query_out),
        .pred_pc_out       (pred_pc_out),
        .pred_taken_in     (pred_taken_in),
        .iq_valid_out      (iq_valid_out),
        .iq_ready_in       (iq_ready_in),
        .iq_inst_out       (iq_inst_out),
        .iq_pc_out         (iq_pc_out),
        .iq_pred_taken_out (iq_pred_taken_out),
        .flush_in          (flush_in),
        .flush_pc_in       (flush_pc_in),
        .icache_clear_in   (icache_clear_in)
    );

    // Predictor: 0 = pc hash, 1 = always taken, 2 = never taken.
    int pred_mode = 0;
    assign pred_taken_in = pred_query_out &
        ((pred_mode == 1) | ((pred_mode == 0) & (pred_pc_out[2] ^ pred_pc_out[5] ^ pred_pc_out[8])));

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Program image: 256 words, address bits [9:2] select the word.
    // kind 0 = plain, 1 = JAL, 2 = conditional branch; off = byte offset.
    logic [31:0] prog_word [256];
    int          prog_kind [256];
    int          prog_off  [256];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return prog_word[a[9:2]];
    endfunction

    function automatic void set_nop(input int i);
        prog_word[i] = 32'h00000013;
        prog_kind[i] = 0;
        prog_off[i]  = 0;
    endfunction

    function automatic void set_jal(input int i, input int off);
        logic [31:0] o;
        o = off;
        prog_word[i] = {o[20], o[10:1], o[11], o[19:12], 5'd0, 7'b1101111};
        prog_kind[i] = 1;
        prog_off[i]  = off;
    endfunction

    function automatic void set_br(input int i, input int off);
        logic [31:0] o;
        o = off;
        prog_word[i] = {o[12], o[10:5], 5'd2, 5'd1, 3'b000, o[4:1], o[11], 7'b1100011};
        prog_kind[i] = 2;
        prog_off[i]  = off;
    endfunction

    function automatic void fill_nops();
        for (int i = 0; i < 256; i++) set_nop(i);
    endfunction

    function automatic void random_prog();
        for (int i = 0; i < 256; i++) begin
            int r;
            int off;
            r   = int'($urandom_range(0, 9));
            off = (int'($urandom_range(0, 64)) - 32) * 4;
            if (r < 4) begin
                prog_word[i] = {$urandom_range(0, 33554431), 7'b0010011} ;
                prog_kind[i] = 0;
                prog_off[i]  = 0;
            end else if (r < 5) begin
                // JALR: no redirect predicted
                prog_word[i] = {$urandom_range(0, 33554431), 7'b1100111};
                prog_kind[i] = 0;
                prog_off[i]  = 0;
            end else if (r < 7) set_jal(i, off);
            else set_br(i, off);
        end
    endfunction

    function automatic logic pred_of(input logic [31:0] pc);
        if (pred_mode == 1) return 1'b1;
        if (pred_mode == 2) return 1'b0;
        return pc[2] ^ pc[5] ^ pc[8];
    endfunction

    function automatic logic model_taken(input logic [31:0] pc);
        int k;
        k = prog_kind[pc[9:2]];
        if (k == 1) return 1'b1;
        if (k == 2) return pred_of(pc);
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] pc);
        int k;
        logic [31:0] o;
        k = prog_kind[pc[9:2]];
        o = prog_off[pc[9:2]];
        if (k == 1 || (k == 2 && pred_of(pc))) return pc + o;
        return pc + 32'd4;
    endfunction

    // Memory and monitor state
    int  mem_lat = 0;
    int  mem_max_lat = 3;
    bit  mem_busy = 0;
    bit  mem_hold = 0;
    bit  mem_force_done = 0;

    logic [31:0] exp_pc = 32'h0;
    bit          abort_exp = 0;
    bit          prev_rdy = 1;
    bit          prev_flush = 0;
    bit          prev_req = 0;
    int          pop_count = 0;
    int          req_count = 0;
    int          query_count = 0;
    logic [31:0] last_req_addr = 32'h0;
    logic [31:0] last_query_pc = 32'h0;
    logic [31:0] last_pop_pc = 32'hFFFFFFFF;
    logic [31:0] after_20 = 32'hFFFFFFFF;
    logic [99:0] snap = '0;

    wire [99:0] out_vec = {mem_req_out, mem_addr_out, mem_abort_out, iq_valid_out,
                           iq_pc_out, iq_inst_out, iq_pred_taken_out};

    // One clock cycle: drive memory response, check outputs, advance model.
    task automatic tick();
        if (!rdy_in) begin
            mem_done_in = 1'($urandom_range(0, 1));
            mem_inst_in = $urandom;
        end else begin
            mem_done_in = 1'b0;
            if (!mem_req_out) mem_busy = 0;
            else if (mem_force_done) begin
                mem_done_in = 1'b1;
                mem_inst_in = mem_word(mem_addr_out);
                mem_busy = 0;
            end else if (!mem_hold) begin
                if (!mem_busy) begin
                    mem_busy = 1;
                    mem_lat = int'($urandom_range(0, mem_max_lat));
                end
                if (mem_lat == 0) begin
                    mem_done_in = 1'b1;
                    mem_inst_in = mem_word(mem_addr_out);
                    mem_busy = 0;
                end else mem_lat--;
            end
        end
        #1;
        if (!prev_rdy) chk("rdy_hold", 32'(out_vec == snap), 32'd1);
        chk("abort", 32'(mem_abort_out), 32'(abort_exp));
        if (prev_flush) chk("flush_empty", 32'(iq_valid_out), 32'd0);
        if (mem_req_out && !prev_req) begin
            req_count++;
            last_req_addr = mem_addr_out;
        end
        prev_req = mem_req_out;
        if (rdy_in && pred_query_out) begin
            query_count++;
            last_query_pc = pred_pc_out;
        end
        if (iq_valid_out && iq_ready_in && rdy_in && !flush_in) begin
            chk("pop_pc", iq_pc_out, exp_pc);
            chk("pop_inst", iq_inst_out, mem_word(exp_pc));
            chk("pop_taken", 32'(iq_pred_taken_out), 32'(model_taken(exp_pc)));
            if (last_pop_pc == 32'h20) after_20 = iq_pc_out;
            last_pop_pc = iq_pc_out;
            exp_pc = model_next(exp_pc);
            pop_count++;
        end
        if (rdy_in && flush_in) exp_pc = flush_pc_in;
        if (rdy_in) abort_exp = flush_in && mem_req_out;
        snap = out_vec;
        prev_rdy = rdy_in;
        prev_flush = rdy_in && flush_in;
        @(negedge clk_in);
    endtask

    task automatic do_reset(input bit check);
        flush_in = 0; icache_clear_in = 0; iq_ready_in = 0; rdy_in = 1;
        mem_done_in = 0; mem_hold = 0; mem_force_done = 0; mem_busy = 0;
        rst_in = 1'b1;
        #2;
        rst_in = 1'b0;
        #1;
        if (check) begin
            chk("rst_mem_req", 32'(mem_req_out), 32'd0);
            chk("rst_mem_addr", mem_addr_out, 32'd0);
            chk("rst_abort", 32'(mem_abort_out), 32'd0);
            chk("rst_query", 32'(pred_query_out), 32'd0);
            chk("rst_pred_pc", pred_pc_out, 32'd0);
            chk("rst_iq_valid", 32'(iq_valid_out), 32'd0);
            chk("rst_iq_pc", iq_pc_out, 32'd0);
            chk("rst_iq_inst", iq_inst_out, 32'd0);
            chk("rst_iq_taken", 32'(iq_pred_taken_out), 32'd0);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        exp_pc = 32'h0; abort_exp = 0; prev_rdy = 1; prev_flush = 0; prev_req = 0;
        req_count = 0; query_count = 0; pop_count = 0;
        last_pop_pc = 32'hFFFFFFFF; after_20 = 32'hFFFFFFFF;
        snap = out_vec;
    endtask

    task automatic wait_req(input int bound);
        int r;
        r = req_count;
        for (int n = 0; n < bound && req_count == r; n++) tick();
        chk("req_timeout", 32'(req_count != r), 32'd1);
    endtask

    initial begin
        int p0;
        int r0;

        // Sequential nops: one miss per word, queue fills to 8 then stops.
        fill_nops();
        do_reset(0);
        iq_ready_in = 0;
        repeat (100) tick();
        chk("fill_reqs", 32'(req_count), 32'd8);
        chk("fill_req_idle", 32'(mem_req_out), 32'd0);
        chk("fill_valid", 32'(iq_valid_out), 32'd1);
        p0 = pop_count;
        iq_ready_in = 1;
        repeat (8) tick();
        chk("fill_drain", 32'(pop_count - p0), 32'd8);

        // Four nops plus JAL -16: cold pass misses, then hit stream.
        fill_nops();
        set_jal(4, -16);
        do_reset(1);
        iq_ready_in = 1;
        repeat (60) tick();
        chk("loop_reqs", 32'(req_count), 32'd5);
        p0 = pop_count;
        repeat (20) tick();
        chk("loop_rate", 32'(pop_count - p0), 32'd20);

        // Full queue with simultaneous push and pop every cycle.
        iq_ready_in = 0;
        repeat (12) tick();
        chk("full_valid", 32'(iq_valid_out), 32'd1);
        r0 = req_count;
        p0 = pop_count;
        iq_ready_in = 1;
        repeat (20) tick();
        chk("full_rate", 32'(pop_count - p0), 32'd20);
        chk("full_no_req", 32'(req_count), 32'(r0));

        // Freeze window mid-stream.
        rdy_in = 0;
        repeat (3) tick();
        rdy_in = 1;
        repeat (5) tick();

        // Cache clear forces a refetch of 0x0.
        icache_clear_in = 1;
        tick();
        icache_clear_in = 0;
        flush_in = 1; flush_pc_in = 32'h0;
        tick();
        flush_in = 0;
        wait_req(20);
        chk("clear_refetch", last_req_addr, 32'h0);

        // BEQ at 0x20 with +8 under taken and not-taken predictions.
        for (int m = 1; m <= 2; m++) begin
            fill_nops();
            set_br(8, 8);
            pred_mode = m;
            do_reset(0);
            iq_ready_in = 1;
            repeat (120) tick();
            chk("br_next", after_20, (m == 1) ? 32'h28 : 32'h24);
            chk("br_query_pc", last_query_pc, 32'h20);
            chk("br_query_cnt", 32'(query_count), 32'd1);
        end

        // Flush to 0x100 while a miss at 0x40 is pending, with coincident done.
        fill_nops();
        pred_mode = 0;
        do_reset(0);
        iq_ready_in = 1;
        mem_hold = 1;
        flush_in = 1; flush_pc_in = 32'h40;
        tick();
        flush_in = 0;
        wait_req(10);
        chk("miss_addr", last_req_addr, 32'h40);
        flush_in = 1; flush_pc_in = 32'h100; mem_force_done = 1;
        tick();
        flush_in = 0; mem_force_done = 0;
        chk("abort_pulse", 32'(mem_abort_out), 32'd1);
        chk("flush_iq_empty", 32'(iq_valid_out), 32'd0);
        chk("flush_req_low", 32'(mem_req_out), 32'd0);
        tick();
        chk("abort_once", 32'(mem_abort_out), 32'd0);
        chk("redirect_req", 32'(mem_req_out), 32'd1);
        chk("redirect_addr", mem_addr_out, 32'h100);
        mem_hold = 0;
        repeat (6) tick();
        flush_in = 1; flush_pc_in = 32'h40;
        tick();
        flush_in = 0;
        wait_req(20);
        chk("dropped_fill", last_req_addr, 32'h40);

        // Randomized programs and control traffic against the stream model.
        for (int round = 0; round < 4; round++) begin
            random_prog();
            pred_mode = (round < 2) ? 0 : round - 1;
            do_reset(0);
            for (int c = 0; c < 1500; c++) begin
                iq_ready_in     = ($urandom_range(0, 9) < 7);
                rdy_in          = ($urandom_range(0, 9) < 9);
                flush_in        = ($urandom_range(0, 49) == 0);
                flush_pc_in     = {21'd0, 9'($urandom_range(0, 511)), 2'b00};
                icache_clear_in = ($urandom_range(0, 99) == 0);
                tick();
            end
            flush_in = 0; icache_clear_in = 0; rdy_in = 1;
            chk("rand_progress", 32'(pop_count > 100), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
